// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: state encoding, parity modes,
// legal parameter bounds and a parity helper.
package uart_pkg;

    localparam int DATA_BITS_MIN   = 5;
    localparam int DATA_BITS_MAX   = 9;
    localparam int STOP_BITS_MIN   = 1;
    localparam int STOP_BITS_MAX   = 2;
    localparam int CLK_DIV_MIN     = 2;
    localparam int CLK_DIV_DEFAULT = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_t;

    // Zero-extension to the widest word leaves the XOR unchanged.
    function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] data,
                                       input parity_mode_t mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake between the host-side source and the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 TX_Valid;
    logic                 TX_Ready;
    logic [DATA_BITS-1:0] TX_Data;

    modport master (output TX_Valid, output TX_Data, input TX_Ready);
    modport slave  (input TX_Valid, input TX_Data, output TX_Ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: ticks once every CLK_DIV enabled cycles.
// Shared with the future receiver, so it knows nothing about frames.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..CLK_DIV-1 while enabled, wrapping at the end of each bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == CNT_LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = enable && !clear && (count == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready word input.
// Optional parity support is compiled in with UART_TX_PARITY_EN.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_frame_if.slave    tx,
`ifdef UART_TX_PARITY_EN
    input  logic              PAR_En_In,
    input  logic              PAR_Odd_In,
`endif
    output logic              TX_Busy,
    output logic              TX_Done_Sig,
    output logic              TX_Pin_Out
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV must be at least 2");
    end

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 ready;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_en;
    logic                 par_bit;
`endif

    assign tx.TX_Ready = ready;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (state == ST_IDLE),
        .enable (state != ST_IDLE),
        .tick   (bit_tick)
    );

    // Frame sequencer: every output is registered so the pin never glitches.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            ready       <= 1'b1;
            TX_Busy     <= 1'b0;
            TX_Done_Sig <= 1'b0;
            TX_Pin_Out  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
`endif
        end else begin
            TX_Done_Sig <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready      <= 1'b1;
                    TX_Busy    <= 1'b0;
                    TX_Pin_Out <= 1'b1;
                    if (tx.TX_Valid && ready) begin
                        shift      <= tx.TX_Data;
`ifdef UART_TX_PARITY_EN
                        par_en     <= PAR_En_In;
                        par_bit    <= parity_of(DATA_BITS_MAX'(tx.TX_Data),
                                                parity_mode_t'(PAR_Odd_In));
`endif
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        ready      <= 1'b0;
                        TX_Busy    <= 1'b1;
                        TX_Pin_Out <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        TX_Pin_Out <= shift[0];
                        shift      <= shift >> 1;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en) begin
                                TX_Pin_Out <= par_bit;
                                state      <= ST_PARITY;
                            end else begin
                                TX_Pin_Out <= 1'b1;
                                state      <= ST_STOP;
                            end
`else
                            TX_Pin_Out <= 1'b1;
                            state      <= ST_STOP;
`endif
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            TX_Pin_Out <= shift[0];
                            shift      <= shift >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        TX_Pin_Out <= 1'b1;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            state       <= ST_IDLE;
                            ready       <= 1'b1;
                            TX_Busy     <= 1'b0;
                            TX_Done_Sig <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ready      <= 1'b1;
                    TX_Busy    <= 1'b0;
                    TX_Pin_Out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (8N1 and 5-bit/2-stop) driven with
// directed and random words, checked against a bit-level frame model.
// Parity cases are included when UART_TX_PARITY_EN is defined.
module tb_uart_tx_frame;

    localparam int DIV = 4;

    logic clk;
    logic rst;

    uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_tx_frame_if #(.DATA_BITS(5)) if_b ();

    logic busy_a, done_a, pin_a;
    logic busy_b, done_b, pin_b;
`ifdef UART_TX_PARITY_EN
    logic par_en_a, par_odd_a, par_en_b, par_odd_b;
`endif

    int checks   = 0;
    int failures = 0;

    uart_tx_frame #(.DATA_BITS(8), .CLK_DIV(DIV), .STOP_BITS(1)) dut_a (
        .CLK         (clk),
        .RST         (rst),
        .tx          (if_a),
`ifdef UART_TX_PARITY_EN
        .PAR_En_In   (par_en_a),
        .PAR_Odd_In  (par_odd_a),
`endif
        .TX_Busy     (busy_a),
        .TX_Done_Sig (done_a),
        .TX_Pin_Out  (pin_a)
    );

    uart_tx_frame #(.DATA_BITS(5), .CLK_DIV(DIV), .STOP_BITS(2)) dut_b (
        .CLK         (clk),
        .RST         (rst),
        .tx          (if_b),
`ifdef UART_TX_PARITY_EN
        .PAR_En_In   (par_en_b),
        .PAR_Odd_In  (par_odd_b),
`endif
        .TX_Busy     (busy_b),
        .TX_Done_Sig (done_b),
        .TX_Pin_Out  (pin_b)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic pin_of(input int sel);
        return (sel == 0) ? pin_a : pin_b;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction
    function automatic logic ready_of(input int sel);
        return (sel == 0) ? if_a.TX_Ready : if_b.TX_Ready;
    endfunction

    task automatic apply_stimulus(input int sel, input logic valid, input logic [8:0] word);
        if (sel == 0) begin
            if_a.TX_Valid = valid;
            if_a.TX_Data  = word[7:0];
        end else begin
            if_b.TX_Valid = valid;
            if_b.TX_Data  = word[4:0];
        end
    endtask

    // Offer a word and return on the first cycle after the handshake edge.
    task automatic start_frame(input int sel, input logic [8:0] word);
        apply_stimulus(sel, 1'b1, word);
        for (int i = 0; i < 200 && !ready_of(sel); i++) @(negedge clk);
        check_output("handshake_ready", {31'd0, ready_of(sel)}, 32'd1);
        @(negedge clk);
    endtask

    // Model: start bit, data LSB first, optional parity, stop bits; each
    // bit lasts DIV cycles and Done follows one cycle after the last stop.
    task automatic check_frame(input string name, input int sel, input logic [8:0] word,
                               input bit par_en, input bit odd);
        bit q[$];
        int dbits = (sel == 0) ? 8 : 5;
        int stops = (sel == 0) ? 1 : 2;
        bit p = odd;
        int total;
        q.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            q.push_back(word[i]);
            p ^= word[i];
        end
        if (par_en) q.push_back(p);
        for (int s = 0; s < stops; s++) q.push_back(1'b1);
        total = q.size() * DIV;
        for (int c = 1; c <= total; c++) begin
            check_output($sformatf("%s_pin_c%0d", name, c), {31'd0, pin_of(sel)}, {31'd0, q[(c-1)/DIV]});
            check_output($sformatf("%s_busy_c%0d", name, c), {31'd0, busy_of(sel)}, 32'd1);
            check_output($sformatf("%s_ready_c%0d", name, c), {31'd0, ready_of(sel)}, 32'd0);
            check_output($sformatf("%s_done_c%0d", name, c), {31'd0, done_of(sel)}, 32'd0);
            @(negedge clk);
        end
        check_output($sformatf("%s_done_at_%0d", name, total + 1), {31'd0, done_of(sel)}, 32'd1);
        check_output($sformatf("%s_ready_at_done", name), {31'd0, ready_of(sel)}, 32'd1);
        check_output($sformatf("%s_busy_at_done", name), {31'd0, busy_of(sel)}, 32'd0);
        check_output($sformatf("%s_pin_at_done", name), {31'd0, pin_of(sel)}, 32'd1);
    endtask

    initial begin
        logic [8:0] w;
        clk = 1'b0;
        rst = 1'b0;
        apply_stimulus(0, 1'b0, 9'd0);
        apply_stimulus(1, 1'b0, 9'd0);
`ifdef UART_TX_PARITY_EN
        par_en_a = 1'b0; par_odd_a = 1'b0;
        par_en_b = 1'b0; par_odd_b = 1'b0;
`endif
        #2 rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_output($sformatf("reset_pin_%0d", s), {31'd0, pin_of(s)}, 32'd1);
            check_output($sformatf("reset_ready_%0d", s), {31'd0, ready_of(s)}, 32'd1);
            check_output($sformatf("reset_busy_%0d", s), {31'd0, busy_of(s)}, 32'd0);
            check_output($sformatf("reset_done_%0d", s), {31'd0, done_of(s)}, 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single word 0xA5");
        start_frame(0, 9'h0A5);
        apply_stimulus(0, 1'b0, 9'd0);
        check_frame("a5", 0, 9'h0A5, 1'b0, 1'b0);
        @(negedge clk);
        check_output("a5_done_single", {31'd0, done_a}, 32'd0);

        $display("[TB] back-to-back 0x00 then 0xFF");
        start_frame(0, 9'h000);
        check_frame("b2b0", 0, 9'h000, 1'b0, 1'b0);
        apply_stimulus(0, 1'b1, 9'h0FF);
        @(negedge clk);
        apply_stimulus(0, 1'b0, 9'h000);
        check_frame("b2b1", 0, 9'h0FF, 1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] data changed after handshake");
        start_frame(0, 9'h03C);
        apply_stimulus(0, 1'b0, 9'h0C3);
        check_frame("latch", 0, 9'h03C, 1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] random words on 8N1");
        for (int k = 0; k < 4; k++) begin
            w = 9'($urandom_range(0, 255));
            start_frame(0, w);
            apply_stimulus(0, 1'b0, 9'($urandom_range(0, 255)));
            check_frame($sformatf("rnd_a%0d", k), 0, w, 1'b0, 1'b0);
            @(negedge clk);
        end

        $display("[TB] 5 data bits, 2 stop bits");
        start_frame(1, 9'h01F);
        apply_stimulus(1, 1'b0, 9'd0);
        check_frame("b1f", 1, 9'h01F, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            w = 9'($urandom_range(0, 31));
            start_frame(1, w);
            apply_stimulus(1, 1'b0, 9'd0);
            check_frame($sformatf("rnd_b%0d", k), 1, w, 1'b0, 1'b0);
            @(negedge clk);
        end

        $display("[TB] reset during data bit 3");
        w = 9'h0F0;
        start_frame(0, w);
        apply_stimulus(0, 1'b0, 9'd0);
        repeat (17) @(negedge clk);
        check_output("pre_reset_bit3", {31'd0, pin_a}, {31'd0, w[3]});
        #1 rst = 1'b1;
        #1;
        check_output("rst_pin_async", {31'd0, pin_a}, 32'd1);
        check_output("rst_ready", {31'd0, if_a.TX_Ready}, 32'd1);
        check_output("rst_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check_output($sformatf("post_rst_done_%0d", c), {31'd0, done_a}, 32'd0);
            check_output($sformatf("post_rst_pin_%0d", c), {31'd0, pin_a}, 32'd1);
            @(negedge clk);
        end
        w = 9'($urandom_range(0, 255));
        start_frame(0, w);
        apply_stimulus(0, 1'b0, 9'd0);
        check_frame("after_rst", 0, w, 1'b0, 1'b0);
        @(negedge clk);

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames");
        par_en_a = 1'b1; par_odd_a = 1'b0;
        start_frame(0, 9'h007);
        apply_stimulus(0, 1'b0, 9'd0);
        par_en_a = 1'b0; par_odd_a = 1'b1;
        check_frame("par_even", 0, 9'h007, 1'b1, 1'b0);
        @(negedge clk);
        par_en_a = 1'b1; par_odd_a = 1'b1;
        start_frame(0, 9'h007);
        apply_stimulus(0, 1'b0, 9'd0);
        par_en_a = 1'b0; par_odd_a = 1'b0;
        check_frame("par_odd", 0, 9'h007, 1'b1, 1'b1);
        @(negedge clk);
        par_en_a = 1'b0; par_odd_a = 1'b0;
        start_frame(0, 9'h007);
        apply_stimulus(0, 1'b0, 9'd0);
        check_frame("par_off", 0, 9'h007, 1'b0, 1'b0);
        @(negedge clk);
        par_en_b = 1'b1; par_odd_b = 1'b0;
        w = 9'($urandom_range(0, 31));
        start_frame(1, w);
        apply_stimulus(1, 1'b0, 9'd0);
        check_frame("par_b", 1, w, 1'b1, 1'b0);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, next generation of the team's fixed 8N1 TX controller.
- Owns its baud timing internally, so no external BPS_CLK input.
- Accepts words through a valid/ready handshake and latches them, so the source may change data after acceptance.
- Supports configurable data width, stop-bit count and optional parity.
- Sits between the UART host-side logic and the TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
CLK_DIV, 434, CLK cycles per bit (50 MHz / 115200); must be >= 2.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  asynchronous, active-high reset.
TX_Valid  input  1  source has a word to send.
TX_Ready  output  1  block can accept a word this cycle.
TX_Data  input  DATA_BITS  word to send; sampled only on a handshake cycle.
TX_Busy  output  1  a frame is in progress.
TX_Done_Sig  output  1  single-cycle pulse at the end of each frame.
TX_Pin_Out  output  1  serial line; idles high.
(PAR_En_In, PAR_Odd_In: present only with UART_TX_PARITY_EN; see Optional Feature.)

Behaviour:
- Clocking and reset: one clock (CLK); reset RST is asynchronous and active-high.
- Reset values: TX_Pin_Out=1, TX_Ready=1, TX_Busy=0, TX_Done_Sig=0, FSM=IDLE, counters=0.
- Reset mid-frame: the line returns high immediately, the frame is abandoned, and no Done pulse is generated.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_Ready=1.
  - On TX_Valid&TX_Ready: latch TX_Data (and parity config) into the shift register, go to START, and clear the baud counter.
  - TX_Ready=0 and TX_Busy=1 from the next cycle.
- START: TX_Pin_Out=0 for exactly CLK_DIV cycles. The first low cycle is the cycle after the handshake.
- DATA:
  - Sends DATA_BITS bits, LSB first.
  - Each bit is held exactly CLK_DIV cycles.
  - The bit counter runs 0..DATA_BITS-1.
- PARITY: one bit period. Entered only when parity is compiled in and enabled for the latched frame; otherwise DATA goes directly to STOP.
- STOP:
  - TX_Pin_Out=1 for STOP_BITS*CLK_DIV cycles.
  - On the last cycle, the next state is IDLE.
  - TX_Done_Sig=1 for exactly the first IDLE cycle.
  - TX_Ready=1 in that same cycle, so back-to-back frames have exactly one idle-high CLK cycle between them.
- Baud counter:
  - Width $clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1 and wraps at CLK_DIV-1.
  - Produces a bit-end tick on the wrap cycle.
  - Held at 0 in IDLE.
- Frame length, handshake to Done: (1+DATA_BITS+P+STOP_BITS)*CLK_DIV + 1 cycles, where P is 0 or 1.
- While busy: TX_Valid is ignored; no data is lost at the block, and the source holds TX_Valid.
- TX_Done_Sig and a new handshake may occur in the same cycle. The new frame proceeds normally.
- Illegal parameter values are a static error: a generate-time $error.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Adds ports PAR_En_In (1 bit) and PAR_Odd_In (1 bit), both sampled on the handshake.
  - If PAR_En_In=1, a PARITY bit follows the data bits.
  - Parity bit value is XOR(data) for even parity (PAR_Odd_In=0), or ~XOR(data) for odd parity (PAR_Odd_In=1).
  - If PAR_En_In=0, the frame is identical to the non-parity build.
- Undefined: the ports, the PARITY state and the parity logic are absent; frames are always data + stop.

Decomposition:
- Package uart_pkg: FSM state encoding constants, parity-mode encoding, legal DATA_BITS/STOP_BITS bounds, default CLK_DIV.
- Sub-module uart_baud_gen:
  - Restartable CLK_DIV counter.
  - Inputs CLK, RST, clear, enable; output bit-end tick.
  - Intended for reuse by the future RX block.

Test Plan:
- DATA_BITS=8, CLK_DIV=4, STOP_BITS=1; send 0xA5 -> line 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; Done pulses once at cycle 41 after the handshake.
- Two back-to-back words 0x00, 0xFF with TX_Valid held high -> second start bit begins exactly 1 idle-high cycle after the first Done; TX_Ready low throughout each frame.
- Change TX_Data on the cycle after the handshake (0x3C to 0xC3) -> the serialised word is still 0x3C.
- STOP_BITS=2, DATA_BITS=5, send 0x1F -> stop high for 8 cycles; total 33 cycles to Done.
- Assert RST during data bit 3 -> TX_Pin_Out=1 asynchronously, TX_Ready=1, no Done pulse; next frame is correct.
- UART_TX_PARITY_EN defined, PAR_En_In=1, send 0x07 -> parity bit 1 when PAR_Odd_In=0, 0 when PAR_Odd_In=1; PAR_En_In=0 -> no parity slot.
